// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared constants and types for the ALU sequencer
// Holds opcode encodings, the sequencer state enum and instruction field positions.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] OP_NEG  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AVG  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_PACK = 3'b110;
    localparam logic [2:0] OP_LDI  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int CIN_BIT = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 10;
    localparam int RA_HI   = 9;
    localparam int RA_LO   = 8;
    localparam int RB_HI   = 7;
    localparam int RB_LO   = 6;
    localparam int IMM_HI  = 9;
    localparam int IMM_LO  = 0;
    localparam int IMM_W   = 10;
    localparam int REG_AW  = 2;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x W register file with captured operand read ports
// Ports: clk/rst (sync, active-high); rd_en captures reg[ra_addr]/reg[rb_addr]
// into opa/opb; we/waddr/wdata write port; dbg_addr/dbg_data combinational read.
module alu_regfile
    import alu_seq_ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [W-1:0]      opa,
    output logic [W-1:0]      opb,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data
);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] regs_d [NREG];
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        opa_d = opa_q;
        opb_d = opb_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
        // Operands come from the stored contents, so a same-cycle write is not seen.
        if (rd_en) begin
            opa_d = regs_q[ra_addr];
            opb_d = regs_q[rb_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    assign opa      = opa_q;
    assign opb      = opb_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - four-state instruction sequencer driving an external ALU
// Ports: clk/rst (sync, active-high); instr_valid/instr_ready/instr handshake;
// alu_a/alu_b/alu_cin/alu_opc to the ALU, alu_w/alu_zer/alu_neg back from it;
// done pulse, result, sticky flag_z/flag_n; dbg_addr/dbg_data register peek.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int NREG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_opc,
    input  logic [W-1:0]      alu_w,
    input  logic              alu_zer,
    input  logic              alu_neg,
    output logic              done,
    output logic [W-1:0]      result,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data
);

    state_e       state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic [W-1:0] res_q, res_d;
    logic         zq_q, zq_d;
    logic         nq_q, nq_d;
    logic [W-1:0] result_q, result_d;
    logic         flag_z_q, flag_z_d;
    logic         flag_n_q, flag_n_d;
    logic         done_q, done_d;

    logic         rd_en;
    logic         wr_en;
    logic [W-1:0] opa, opb;
    logic [2:0]   ir_op;
    logic [W-1:0] imm_sext;

    assign ir_op    = ir_q[OP_HI:OP_LO];
    assign imm_sext = {{(W-IMM_W){ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO]};

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        res_d       = res_q;
        zq_d        = zq_q;
        nq_d        = nq_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        instr_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = (ir_op == OP_LDI) ? imm_sext : alu_w;
                zq_d    = alu_zer;
                nq_d    = alu_neg;
                state_d = ST_WB;
            end
            ST_WB: begin
                wr_en    = 1'b1;
                result_d = res_q;
                // done is registered so it rises together with the new result and flags.
                done_d   = 1'b1;
                if (ir_op != OP_LDI) begin
                    flag_z_d = zq_q;
                    flag_n_d = nq_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            res_q    <= '0;
            zq_q     <= 1'b0;
            nq_q     <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            zq_q     <= zq_d;
            nq_q     <= nq_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            done_q   <= done_d;
        end
    end

    alu_regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .ra_addr  (ir_q[RA_HI:RA_LO]),
        .rb_addr  (ir_q[RB_HI:RB_LO]),
        .opa      (opa),
        .opb      (opb),
        .we       (wr_en),
        .waddr    (ir_q[RD_HI:RD_LO]),
        .wdata    (res_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_a   = opa;
    assign alu_b   = opb;
    assign alu_opc = ir_op;
    assign alu_cin = ir_q[CIN_BIT];
    assign done    = done_q;
    assign result  = result_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a, alu_b, alu_w;
    logic        alu_cin, alu_zer, alu_neg;
    logic [2:0]  alu_opc;
    logic        done;
    logic [15:0] result;
    logic        flag_z, flag_n;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.W(16), .NREG(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opc(alu_opc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .done(done), .result(result), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU standing in for the external combinational unit.
    always_comb begin
        case (alu_opc)
            3'b000:  alu_w = -alu_a;
            3'b001:  alu_w = alu_a + 16'd1;
            3'b010:  alu_w = alu_a + alu_b + {15'd0, alu_cin};
            3'b011:  alu_w = 16'(({1'b0, alu_a} + {1'b0, alu_b}) >> 1);
            3'b100:  alu_w = alu_a & alu_b;
            3'b101:  alu_w = alu_a | alu_b;
            3'b110:  alu_w = {alu_a[7:0], alu_b[7:0]};
            default: alu_w = ~alu_a;
        endcase
        alu_zer = (alu_w == 16'd0);
        alu_neg = alu_w[15];
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic cin,
                                        input logic [1:0] rd, input logic [1:0] ra,
                                        input logic [1:0] rb);
        return {op, cin, rd, ra, rb, 6'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [9:0] imm);
        return {3'b111, 1'b0, rd, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input logic [1:0] addr, input logic [15:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Issues one instruction and checks the 4-cycle handshake-to-done timing.
    task automatic run_instr(input logic [15:0] word, input string tag);
        int waitc;
        @(negedge clk);
        instr = word;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check($sformatf("%s accept", tag), {15'd0, instr_ready}, 16'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("%s busy%0d", tag, k), {14'd0, instr_ready, done}, 16'd0);
        end
        @(negedge clk);
        check($sformatf("%s done", tag), {15'd0, done}, 16'd1);
    endtask

    logic [8:0] ready_seen, done_seen;
    logic       any_done;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0;
        dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst ready", {15'd0, instr_ready}, 16'd1);
        check("rst done", {15'd0, done}, 16'd0);
        check("rst alu_a", alu_a, 16'h0);
        check("rst alu_b", alu_b, 16'h0);
        check("rst alu_ctl", {12'd0, alu_opc, alu_cin}, 16'h0);
        check("rst result", result, 16'h0);
        check("rst flags", {14'd0, flag_z, flag_n}, 16'h0);
        check_reg(2'd3, 16'h0, "rst R3");

        // LOADI then ADD with carry-in
        run_instr(ldi(2'd1, 10'd5), "ldi R1");
        check("ldi R1 result", result, 16'h0005);
        run_instr(ldi(2'd2, 10'd7), "ldi R2");
        run_instr(enc(3'b010, 1'b1, 2'd3, 2'd1, 2'd2), "add");
        check("add result", result, 16'h000D);
        check_reg(2'd3, 16'h000D, "add R3");
        check("add flags", {14'd0, flag_z, flag_n}, 16'h0);
        check("add alu_a hold", alu_a, 16'h0005);
        check("add alu_b hold", alu_b, 16'h0007);
        check("add alu_ctl hold", {12'd0, alu_opc, alu_cin}, 16'h0005);

        // NEG
        run_instr(enc(3'b000, 1'b0, 2'd0, 2'd1, 2'd0), "neg");
        check("neg result", result, 16'hFFFB);
        check("neg flags zn", {14'd0, flag_z, flag_n}, 16'h0001);
        check_reg(2'd0, 16'hFFFB, "neg R0");

        // AND, zero flag, LOADI sign extension leaves flags untouched
        run_instr(ldi(2'd1, 10'h0F0), "ldi R1 f0");
        run_instr(ldi(2'd2, 10'h1F0), "ldi R2 1f0");
        check("ldi 1f0 result", result, 16'h01F0);
        run_instr(enc(3'b100, 1'b0, 2'd0, 2'd1, 2'd2), "and1");
        check("and1 result", result, 16'h00F0);
        check("and1 flags", {14'd0, flag_z, flag_n}, 16'h0);
        run_instr(ldi(2'd2, 10'h100), "ldi R2 100");
        run_instr(enc(3'b100, 1'b0, 2'd0, 2'd1, 2'd2), "and2");
        check("and2 result", result, 16'h0000);
        check("and2 flags", {14'd0, flag_z, flag_n}, 16'h0002);
        run_instr(ldi(2'd3, 10'h3FF), "ldi R3 3ff");
        check("ldi 3ff result", result, 16'hFFFF);
        check_reg(2'd3, 16'hFFFF, "ldi R3");
        check("ldi flags kept", {14'd0, flag_z, flag_n}, 16'h0002);

        // rd == ra == rb uses the old value
        run_instr(ldi(2'd1, 10'd3), "ldi R1 3");
        run_instr(enc(3'b010, 1'b0, 2'd1, 2'd1, 2'd1), "self add");
        check_reg(2'd1, 16'h0006, "self add R1");

        // instr_valid held high: one accept per 4 cycles
        @(negedge clk);
        instr = enc(3'b010, 1'b0, 2'd1, 2'd1, 2'd1);
        instr_valid = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            if (n > 0) @(negedge clk);
            ready_seen[n] = instr_ready;
            done_seen[n]  = done;
        end
        instr_valid = 1'b0;
        check("held ready pattern", {7'd0, ready_seen}, 16'h0111);
        check("held done pattern", {7'd0, done_seen}, 16'h0110);
        check_reg(2'd1, 16'h0018, "held R1");
        check("held result", result, 16'h0018);

        // Reset during EXEC abandons the instruction
        @(negedge clk);
        instr = enc(3'b010, 1'b0, 2'd3, 2'd1, 2'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec alu_a", alu_a, 16'h0018);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid rst ready", {15'd0, instr_ready}, 16'd1);
        check("mid rst alu_a", alu_a, 16'h0);
        check("mid rst alu_b", alu_b, 16'h0);
        check("mid rst alu_ctl", {12'd0, alu_opc, alu_cin}, 16'h0);
        check("mid rst result", result, 16'h0);
        any_done = done;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        check("mid rst no done", {15'd0, any_done}, 16'd0);
        check_reg(2'd3, 16'h0, "mid rst R3");
        check_reg(2'd1, 16'h0, "mid rst R1");

        run_instr(ldi(2'd2, 10'h200), "ldi after rst");
        check("ldi 200 result", result, 16'hFE00);
        check("post rst flags", {14'd0, flag_z, flag_n}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multicycle instruction sequencer that owns a small register file and drives the 16-bit ALU (ports inA, inB, inC, opc; results outW, zer, neg).
- Accepts one 16-bit instruction per valid/ready handshake and reads operands into registered ALU inputs.
- Captures the ALU result and flags, then writes back the destination register.
- Sits between the instruction source (testbench or upstream fetch) and the combinational ALU; the ALU itself is instantiated outside this block.

Parameters:
- W, 16, datapath width; must match the ALU.
- NREG, 4, number of general registers; addressed by 2-bit fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  instruction word: [15:13] op, [12] cin, [11:10] rd, [9:8] ra, [7:6] rb, [5:0] reserved. For op=111, [9:0] is imm.
- alu_a  out  W  to ALU inA.
- alu_b  out  W  to ALU inB.
- alu_cin  out  1  to ALU inC.
- alu_opc  out  3  to ALU opc.
- alu_w  in  W  from ALU outW.
- alu_zer  in  1  from ALU zer.
- alu_neg  in  1  from ALU neg.
- done  out  1  one-cycle pulse when write-back completes.
- result  out  W  last written value; holds until the next write-back.
- flag_z  out  1  sticky zero flag from the last ALU op.
- flag_n  out  1  sticky negative flag from the last ALU op.
- dbg_addr  in  2  debug register select.
- dbg_data  out  W  combinational read of reg[dbg_addr].

Behaviour:
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. If instr_valid, latch instr into ir and go to READ. Otherwise stay in IDLE.
- READ: opa<=reg[ra], opb<=reg[rb] from the current register contents. Go to EXEC.
- EXEC: alu_a=opa, alu_b=opb, alu_opc=ir.op, alu_cin=ir.cin; the ALU settles combinationally.
  - At the end of EXEC: res<=alu_w, zq<=alu_zer, nq<=alu_neg.
  - For op=111 (LOADI), ignore the ALU and set res <= sign-extend(imm[9:0]).
  - Go to WB.
- WB: reg[rd]<=res and result<=res. done=1 for exactly this cycle.
  - For op!=111, flag_z<=zq and flag_n<=nq. For LOADI, the flags are unchanged.
  - Go to IDLE.
- Latency: a handshake accepted at edge N gives done high in the cycle after edge N+3. Throughput is 1 instruction per 4 cycles.
- instr_ready is 0 in READ, EXEC and WB. instr_valid is ignored outside IDLE; the source must hold it until accepted.
- alu_a, alu_b, alu_opc, alu_cin are driven from opa, opb and ir at all times. They are stable through EXEC and hold their values outside it.
- rd==ra or rd==rb: operands are read in READ, before WB, so the old value is used.
- Register writes occur only in WB. dbg_data reflects a write from the cycle after WB.
- Reset: every register (FSM, ir, opa, opb, res, reg file, result, flags) clears to 0, including mid-operation.
  - The in-flight instruction is abandoned with no write-back and no done.
  - After reset: state=IDLE, instr_ready=1, done=0, alu_* outputs all 0.
- Reserved bits [5:0] are ignored, except as part of imm under LOADI.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_NEG=000, OP_INC=001, OP_ADD=010, OP_AVG=011, OP_AND=100, OP_OR=101, OP_PACK=110, OP_LDI=111.
  - State enum.
  - Instruction field bit positions.
- One natural sub-module: alu_regfile (NREG x W, two synchronous-capture read ports, one write port, one combinational debug port, synchronous reset clear).

Test Plan:
- LOADI R1=5, R2=7 (imm sign-extended), then ADD rd=3 ra=1 rb=2 cin=1 -> done with result=0x000D, dbg R3=0x000D, flag_z=0, flag_n=0. Each done exactly 4 cycles after its accept.
- NEG rd=0 ra=1 (R1=5) -> result=0xFFFB, flag_n=1, flag_z=0.
- LOADI R1=0x0F0 and R2=0x1F0 (imm 0x1F0 sign-extends to 0x01F0), then AND rd=0 ra=1 rb=2 -> result=0x00F0. LOADI R2=0x100, then AND -> result=0x0000, flag_z=1. A following LOADI R3=0x3FF -> R3=0xFFFF with flag_z still 1.
- ADD rd=1 ra=1 rb=1 with R1=3 -> R1=6 (old value read). instr_valid held high continuously -> instr_ready low in READ, EXEC and WB, and exactly one accept per 4 cycles.
- Assert rst in the EXEC cycle of an ADD -> no done, the target register stays 0, next cycle instr_ready=1, and all alu_* outputs are 0.
